// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder: access sizes, FSM states and
// lane helpers that the pipeline's forwarding logic can reuse.
package data_mem_responder_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic {
        IDLE = 1'b0,
        RMW  = 1'b1
    } state_e;

    function automatic logic is_misaligned(input size_e size, input logic [1:0] off);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = off[0];
            SZ_WORD: bad = |off;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Shift the lane to the top of the word, then shift back down logically or
    // arithmetically; this extends without a separate sign-fill step.
    function automatic logic [31:0] extract_lane(input logic [31:0] word, input logic [1:0] off,
                                                 input size_e size, input logic uns);
        logic [31:0] top;
        logic [31:0] res;
        case (size)
            SZ_BYTE: begin
                top = word << (5'd24 - {off, 3'b000});
                res = uns ? (top >> 5'd24) : 32'($signed(top) >>> 5'd24);
            end
            SZ_HALF: begin
                top = word << (5'd16 - {off, 3'b000});
                res = uns ? (top >> 5'd16) : 32'($signed(top) >>> 5'd16);
            end
            default: begin
                top = word;
                res = word;
            end
        endcase
        return res;
    endfunction

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_word, input logic [31:0] wdata,
                                                input logic [1:0] off, input size_e size);
        logic [31:0] mask;
        logic [31:0] data;
        case (size)
            SZ_BYTE: mask = 32'h0000_00FF << {off, 3'b000};
            SZ_HALF: mask = 32'h0000_FFFF << {off, 3'b000};
            default: mask = 32'hFFFF_FFFF;
        endcase
        data = wdata << {off, 3'b000};
        return (old_word & ~mask) | (data & mask);
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port DEPTH x 32 synchronous RAM with registered read; one access per cycle,
// read returns the old contents when the same cycle writes.
module dmem_ram #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH];

    // NOTE: storage arrays get no reset; clearing them would force a flop-based
    // implementation instead of a RAM macro, and software never relies on it.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        o_rdata <= r_mem[i_addr];
    end

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage data-memory responder: loads and word stores in one cycle, byte and
// halfword stores as a read-modify-write that stalls the requester for a cycle.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    state_e         r_state;
    state_e         w_next_state;

    logic [AW-1:0]  r_idx;
    logic [1:0]     r_off;
    size_e          r_size;
    logic           r_uns;
    logic [31:0]    r_wdata;

    logic           r_resp_valid;
    logic           r_resp_err;
    logic           r_resp_load;

    logic           w_ram_we;
    logic [AW-1:0]  w_ram_addr;
    logic [31:0]    w_ram_wdata;
    logic [31:0]    w_ram_rdata;

    size_e          w_size;
    logic           w_err;
    logic           w_accept;
    logic           w_subword_store;
    logic           w_unused_addr;

    assign w_size          = size_e'(req_size);
    assign w_err           = is_misaligned(w_size, req_addr[1:0]);
    assign w_accept        = req_valid && req_ready;
    assign w_subword_store = req_we && !w_err && (w_size == SZ_BYTE || w_size == SZ_HALF);
    assign w_unused_addr   = ^req_addr[31:AW+2];

    dmem_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: combinational blocks use blocking assignments with every output
    // defaulted first, so no path leaves a signal unassigned and a latch appears.
    always_comb begin
        w_next_state = r_state;
        req_ready    = 1'b0;
        w_ram_we     = 1'b0;
        w_ram_addr   = req_addr[AW+1:2];
        w_ram_wdata  = req_wdata;
        case (r_state)
            IDLE: begin
                req_ready = !rst;
                if (w_accept) begin
                    if (w_subword_store) begin
                        w_next_state = RMW;
                    end else if (req_we && !w_err) begin
                        w_ram_we = 1'b1;
                    end
                end
            end
            RMW: begin
                // A reset landing in this cycle drops the merged write.
                w_ram_addr   = r_idx;
                w_ram_wdata  = merge_lanes(w_ram_rdata, r_wdata, r_off, r_size);
                w_ram_we     = !rst;
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Request fields are captured on every accept; they serve both the load
    // response in the next cycle and the merge of a pending sub-word store.
    always_ff @(posedge clk) begin
        if (r_state == IDLE && w_accept) begin
            r_idx   <= req_addr[AW+1:2];
            r_off   <= req_addr[1:0];
            r_size  <= w_size;
            r_uns   <= req_unsigned;
            r_wdata <= req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_load  <= 1'b0;
        end else begin
            r_resp_valid <= 1'b0;
            if (r_state == IDLE && w_accept) begin
                r_resp_valid <= !w_subword_store;
                r_resp_err   <= w_err;
                r_resp_load  <= !req_we && !w_err;
            end else if (r_state == RMW) begin
                r_resp_valid <= 1'b1;
                r_resp_err   <= 1'b0;
                r_resp_load  <= 1'b0;
            end
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_err   = r_resp_err;
    assign resp_rdata = r_resp_load ? extract_lane(w_ram_rdata, r_off, r_size, r_uns) : 32'h0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed and randomized bench for data_mem_responder against a word-array model
// that computes load/store results with plain integer arithmetic.
module tb_data_mem_responder;

    localparam int DEPTH = 1024;
    localparam int AW    = 10;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int n_tests;
    int n_fail;

    logic [31:0] model_mem [DEPTH];

    data_mem_responder #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference behaviour: err/rdata/latency of one request, updating the word array.
    function automatic void model_step(input logic we, input logic [1:0] sz, input logic uns,
                                       input logic [31:0] addr, input logic [31:0] wd,
                                       output logic err, output logic [31:0] rd, output int lat);
        longint unsigned word, lane, newlane, modv;
        int idx, off, nb;
        idx = int'((addr / 4) % DEPTH);
        off = int'(addr % 4);
        err = (sz == 2'd3) || (sz == 2'd1 && (off % 2) != 0) || (sz == 2'd2 && off != 0);
        rd  = 32'h0;
        lat = 1;
        if (err) return;
        nb   = 1 << sz;
        modv = 64'd1 << (8 * nb);
        word = longint'(model_mem[idx]);
        lane = (word >> (8 * off)) % modv;
        if (!we) begin
            if (!uns && lane >= modv / 2) lane = lane - modv;
            rd = lane[31:0];
        end else begin
            newlane = longint'(wd) % modv;
            word = word - (lane << (8 * off)) + (newlane << (8 * off));
            model_mem[idx] = word[31:0];
            lat = (nb == 4) ? 1 : 2;
        end
    endfunction

    // Called at a falling edge; returns at the falling edge where the response was checked.
    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd, input string tag);
        logic        exp_err;
        logic [31:0] exp_rd;
        int          lat;
        int          n;
        model_step(we, sz, uns, addr, wd, exp_err, exp_rd, lat);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        n = 0;
        while (req_ready !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        check({tag, "/ready"}, {31'b0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        if (lat == 2) begin
            check({tag, "/rmw_ready"}, {31'b0, req_ready}, 32'd0);
            check({tag, "/rmw_valid"}, {31'b0, resp_valid}, 32'd0);
            @(negedge clk);
        end
        check({tag, "/valid"}, {31'b0, resp_valid}, 32'd1);
        check({tag, "/err"}, {31'b0, resp_err}, {31'b0, exp_err});
        check({tag, "/rdata"}, resp_rdata, exp_rd);
    endtask

    initial begin
        logic        e_err;
        logic [31:0] e_rd;
        int          e_lat;
        n_tests      = 0;
        n_fail       = 0;
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;

        repeat (3) @(negedge clk);
        check("rst/ready", {31'b0, req_ready}, 32'd0);
        check("rst/valid", {31'b0, resp_valid}, 32'd0);
        check("rst/err", {31'b0, resp_err}, 32'd0);
        check("rst/rdata", resp_rdata, 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst/ready", {31'b0, req_ready}, 32'd1);
        @(negedge clk);

        // Word write then read back, plus one-cycle pulse width.
        do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, "st_w10");
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, "ld_w10");
        @(negedge clk);
        check("pulse_one", {31'b0, resp_valid}, 32'd0);

        // Extension of byte and halfword loads.
        do_req(1'b1, 2'd2, 1'b0, 32'h20, 32'h80FF7F01, "st_w20");
        do_req(1'b0, 2'd0, 1'b0, 32'h23, 32'h0, "ld_sb23");
        do_req(1'b0, 2'd0, 1'b1, 32'h23, 32'h0, "ld_ub23");
        do_req(1'b0, 2'd1, 1'b0, 32'h20, 32'h0, "ld_sh20");
        do_req(1'b0, 2'd1, 1'b0, 32'h22, 32'h0, "ld_sh22");
        do_req(1'b0, 2'd1, 1'b1, 32'h22, 32'h0, "ld_uh22");
        do_req(1'b0, 2'd0, 1'b0, 32'h20, 32'h0, "ld_sb20");

        // Sub-word read-modify-write.
        do_req(1'b1, 2'd2, 1'b0, 32'h30, 32'h11223344, "st_w30");
        do_req(1'b1, 2'd0, 1'b0, 32'h31, 32'h000000AA, "st_b31");
        do_req(1'b0, 2'd2, 1'b0, 32'h30, 32'h0, "ld_w30a");
        check("rmw_b31_word", model_mem[12], 32'h1122AA44);
        do_req(1'b1, 2'd1, 1'b0, 32'h32, 32'hFFFF5566, "st_h32");
        do_req(1'b0, 2'd2, 1'b0, 32'h30, 32'h0, "ld_w30b");

        // Load held while the block is in RMW is taken at the first ready edge.
        model_step(1'b1, 2'd0, 1'b0, 32'h33, 32'h77, e_err, e_rd, e_lat);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_addr = 32'h33; req_wdata = 32'h77;
        @(negedge clk);
        req_we = 1'b0; req_size = 2'd2; req_addr = 32'h30; req_wdata = 32'h0;
        check("held/busy_ready", {31'b0, req_ready}, 32'd0);
        check("held/busy_valid", {31'b0, resp_valid}, 32'd0);
        @(negedge clk);
        check("held/st_valid", {31'b0, resp_valid}, 32'd1);
        check("held/st_rdata", resp_rdata, 32'd0);
        check("held/ready", {31'b0, req_ready}, 32'd1);
        model_step(1'b0, 2'd2, 1'b0, 32'h30, 32'h0, e_err, e_rd, e_lat);
        @(negedge clk);
        req_valid = 1'b0;
        check("held/ld_valid", {31'b0, resp_valid}, 32'd1);
        check("held/ld_rdata", resp_rdata, e_rd);

        // Misaligned and reserved accesses.
        do_req(1'b1, 2'd2, 1'b0, 32'h40, 32'hCAFEF00D, "st_w40");
        do_req(1'b1, 2'd2, 1'b0, 32'h42, 32'h12345678, "st_w42_mis");
        do_req(1'b0, 2'd1, 1'b0, 32'h41, 32'h0, "ld_h41_mis");
        do_req(1'b1, 2'd3, 1'b0, 32'h40, 32'h0, "st_rsvd");
        do_req(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, "ld_w40");

        // Address wrap modulo DEPTH words.
        do_req(1'b1, 2'd2, 1'b0, 32'(4 * DEPTH + 8), 32'hA5A55A5A, "st_wrap");
        do_req(1'b0, 2'd2, 1'b0, 32'h8, 32'h0, "ld_wrap");

        // Reset during RMW: merged write dropped, no response, requests ignored under reset.
        do_req(1'b1, 2'd2, 1'b0, 32'h50, 32'h11112222, "st_w50");
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd1; req_addr = 32'h52; req_wdata = 32'hBEEF;
        @(negedge clk);
        req_size = 2'd2; req_addr = 32'h50; req_wdata = 32'h0;
        check("rstrmw/busy", {31'b0, req_ready}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("rstrmw/valid0", {31'b0, resp_valid}, 32'd0);
        check("rstrmw/ready0", {31'b0, req_ready}, 32'd0);
        @(negedge clk);
        check("rstrmw/valid1", {31'b0, resp_valid}, 32'd0);
        rst = 1'b0;
        req_valid = 1'b0;
        #1;
        check("rstrmw/ready_after", {31'b0, req_ready}, 32'd1);
        @(negedge clk);
        check("rstrmw/valid2", {31'b0, resp_valid}, 32'd0);
        do_req(1'b0, 2'd2, 1'b0, 32'h50, 32'h0, "ld_w50");

        // Randomized traffic over a preloaded 32-word window, upper address bits varied.
        for (int i = 0; i < 32; i++) begin
            do_req(1'b1, 2'd2, 1'b0, 32'(4 * i), $urandom, "preload");
        end
        for (int i = 0; i < 200; i++) begin
            logic        we;
            logic [1:0]  sz;
            logic        uns;
            logic [31:0] addr;
            int          r;
            we  = 1'($urandom_range(0, 1));
            uns = 1'($urandom_range(0, 1));
            r   = int'($urandom_range(0, 9));
            sz  = (r == 0) ? 2'd3 : 2'(r % 3);
            addr = 32'($urandom_range(0, 127));
            if ($urandom_range(0, 3) != 0 && sz != 2'd3) begin
                addr = addr & ~32'((1 << sz) - 1);
            end
            addr = addr | (32'($urandom_range(0, 3)) << 12);
            do_req(we, sz, uns, addr, $urandom, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Responder end of the MEM-stage data-memory interface. Accepts load/store requests from the pipeline's memory stage over a valid/ready handshake and owns a single-port, word-wide synchronous RAM without byte enables. Returns sign/zero-extended load data and store completions on a registered response channel. Byte and halfword stores take a two-cycle read-modify-write, during which the block stalls the requester.

## Interface
Parameters:
- DEPTH, 1024: number of 32-bit words in the RAM (power of two).
- AW, 10: word-index width, equal to log2(DEPTH).

Ports:
- clk  in  1  single clock; everything updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  access size; encoding under Operation.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], halfword in [15:0]).
- resp_valid  out  1  one-cycle pulse: response present.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned access or reserved size.

## Operation
- Size encoding: 00 = byte, 01 = halfword, 10 = word, 11 = reserved.
- Byte lanes are little-endian: byte offset 0 maps to bits [7:0]; halfword offset 2 maps to bits [31:16].
- RAM index is req_addr[AW+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH words.
- Error cases: size 11; halfword with addr[0]=1; word with addr[1:0]≠0.
  - The request is still accepted.
  - No RAM write occurs.
  - The response has resp_err=1 and resp_rdata=0.
- States:
  - IDLE: req_ready=1.
  - RMW: req_ready=0.
- IDLE, handshake with a load, word store, or error: the block stays in IDLE and responds next cycle.
- IDLE, handshake with a valid byte or halfword store:
  - The block reads the addressed word and latches index, lane offset, size and wdata.
  - It moves to RMW.
- RMW: the block merges the new lanes into the read word, writes it back, and returns to IDLE.
- Loads extract the addressed lane from the RAM read data and extend it per req_unsigned. Word loads pass through unchanged.
- RAM contents are not initialised or cleared by reset.

## Timing
- Reset values: state IDLE, resp_valid=0, resp_rdata=0, resp_err=0. req_ready=0 while rst is high.
- Load: handshake at edge N; resp_valid=1 with data during cycle N+1 (latency 1).
- Word store or error: RAM written at edge N (stores only); resp_valid during cycle N+1.
- Sub-word store:
  - Read at edge N; merged write at edge N+1; resp_valid during cycle N+2.
  - req_ready is 0 during cycle N+1.
- Back-to-back:
  - A new request may be accepted in the same cycle that resp_valid is high.
  - A load accepted the cycle after a word store returns the newly written data.
  - A request held by the requester while req_ready=0 is accepted at the first edge where ready is high.
- resp_valid is high for exactly one cycle per accepted request. The requester cannot back-pressure responses.
- Reset during RMW: the pending merged write is dropped, no response is issued, and the state returns to IDLE.
- When rst and req_valid are both high, nothing is accepted.

## Structure
- Shared package:
  - Size encodings: SZ_BYTE, SZ_HALF, SZ_WORD.
  - State enum: IDLE, RMW.
  - Helper functions for lane extraction/extension and lane merging, so the pipeline's forwarding logic can reuse them.
- Sub-module: dmem_ram, a single-port synchronous RAM (DEPTH x 32, one read or write per cycle, registered read). The responder holds the FSM, alignment check, extract/extend and merge logic.

## Test plan
- Write then read a word: store 0xDEADBEEF at 0x10, then load word 0x10 → resp_valid one cycle after each request, rdata=0xDEADBEEF, err=0.
- Signed and unsigned byte loads: with 0x80FF7F01 at 0x20:
  - signed byte at 0x23 → 0xFFFFFF80;
  - unsigned byte at 0x23 → 0x00000080;
  - signed halfword at 0x20 → 0x00007F01.
- Byte-store read-modify-write: with 0x11223344 at 0x30, store byte 0xAA at 0x31.
  - req_ready is low for one cycle; the response arrives 2 cycles after the handshake.
  - A following word load returns 0x1122AA44.
- Misaligned accesses: a word store at 0x42 and a halfword load at 0x41 each give err=1 and rdata=0. The word at 0x40 is unchanged.
- Wrap-around: store a word at byte address 4·DEPTH+8, then load from 0x8 → same data.
- Reset mid-RMW: assert rst in the RMW cycle of a halfword store → no resp_valid, memory word unchanged, state IDLE, req_ready=1 after rst drops.
